// File: rtl/csr_priv_pkg.sv
// csr_priv_pkg: shared types and constants for the privileged CSR responder.
// The optional lock behaviour is controlled by the CSR_LOCK_EN macro (see csr_priv_responder).
package csr_priv_pkg;

  typedef enum logic [1:0] {
    PRIV_U    = 2'b00,
    PRIV_S    = 2'b01,
    PRIV_RSVD = 2'b10,
    PRIV_M    = 2'b11
  } priv_e;

  typedef enum logic [1:0] {
    RSP_OK     = 2'b00,
    RSP_PRIV   = 2'b01,
    RSP_DECODE = 2'b10,
    RSP_RO     = 2'b11
  } rsp_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CHECK = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

  localparam int NUM_REGS = 8;

  localparam logic [2:0] SCRATCH_IDX   = 3'd0;
  localparam logic [2:0] STATUS_IDX    = 3'd1;
  localparam logic [2:0] CTRL_IDX      = 3'd2;
  localparam logic [2:0] VIOL_CNT_IDX  = 3'd3;
  localparam logic [2:0] STACK_REG_IDX = 3'd4;
  localparam logic [2:0] PC_REG_IDX    = 3'd5;
  localparam logic [2:0] EPC_IDX       = 3'd6;
  localparam logic [2:0] LOCK_IDX      = 3'd7;

  // Minimum privilege per register index; no address is exempt.
  localparam priv_e MIN_PRIV [NUM_REGS] = '{
    PRIV_U, PRIV_S, PRIV_S, PRIV_S, PRIV_M, PRIV_M, PRIV_M, PRIV_M
  };

endpackage

// File: rtl/csr_priv_checker.sv
// csr_priv_checker: combinational decode and privilege check for one request.
// Fault priority is DECODE > PRIV > RO/LOCK.
module csr_priv_checker
  import csr_priv_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR = 12'h060
) (
  input  logic [11:0] addr_i,
  input  logic        write_i,
  input  logic [1:0]  priv_i,
  input  logic        lock_i,
  output logic        authorized_o,
  output rsp_code_e   code_o
);

  logic [11:0] offset;
  logic [2:0]  idx;
  logic        in_range;
  logic        protected_idx;

  assign offset        = addr_i - BASE_ADDR;
  assign idx           = offset[2:0];
  assign in_range      = (offset[11:3] == 9'd0);
  assign protected_idx = (idx == STACK_REG_IDX) || (idx == PC_REG_IDX) || (idx == EPC_IDX);

  // Resolve the single highest-priority fault code for the request.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    code_o = RSP_OK;
    if (!in_range) begin
      code_o = RSP_DECODE;
    end else if ((priv_i == PRIV_RSVD) || (priv_i < MIN_PRIV[idx])) begin
      code_o = RSP_PRIV;
    end else if (write_i && ((idx == VIOL_CNT_IDX) || (lock_i && protected_idx))) begin
      code_o = RSP_RO;
    end
  end

  assign authorized_o = (code_o == RSP_OK);

endmodule

// File: rtl/csr_priv_responder.sv
// csr_priv_responder: target end of the privileged register-access interface.
// IDLE accepts a request, CHECK decodes/commits/faults, RESP holds the response.
// Optional feature macro: CSR_LOCK_EN (sticky LOCK[0] write-protects STACK_REG, PC_REG, EPC).
module csr_priv_responder
  import csr_priv_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter logic [11:0] BASE_ADDR  = 12'h060,
  parameter int          VIOL_CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [11:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_priv,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        rsp_code,
  output logic              excp
);

  state_e                state_q, state_d;
  logic                  write_q;
  logic [11:0]           addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [1:0]            priv_q;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic [VIOL_CNT_W-1:0] viol_cnt_q, viol_cnt_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  rsp_code_e             rsp_code_q, rsp_code_d;

  logic                  authorized;
  rsp_code_e             chk_code;
  logic                  lock;
  logic [2:0]            idx;
  logic [DATA_W-1:0]     rd_val;
  logic [DATA_W-1:0]     wr_val;
  logic                  reg_we;

  // Low address bits of (addr - BASE_ADDR); range is checked in the checker.
  assign idx = addr_q[2:0] - BASE_ADDR[2:0];

`ifdef CSR_LOCK_EN
  assign lock = regs_q[LOCK_IDX][0];
`else
  assign lock = 1'b0;
`endif

  csr_priv_checker #(.BASE_ADDR(BASE_ADDR)) u_checker (
    .addr_i       (addr_q),
    .write_i      (write_q),
    .priv_i       (priv_q),
    .lock_i       (lock),
    .authorized_o (authorized),
    .code_o       (chk_code)
  );

  assign rd_val = (idx == VIOL_CNT_IDX) ? DATA_W'(viol_cnt_q) : regs_q[idx];

  // Write value; LOCK[0] can only be set, never cleared, when locking is built in.
  always_comb begin
    wr_val = wdata_q;
`ifdef CSR_LOCK_EN
    if (idx == LOCK_IDX) begin
      wr_val[0] = wdata_q[0] | regs_q[LOCK_IDX][0];
    end
`endif
  end

  // Next-state and response logic for the IDLE/CHECK/RESP sequence.
  always_comb begin
    state_d     = state_q;
    viol_cnt_d  = viol_cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_code_d  = rsp_code_q;
    reg_we      = 1'b0;
    excp        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d     = ST_RESP;
        rsp_err_d   = !authorized;
        rsp_code_d  = chk_code;
        rsp_rdata_d = '0;
        if (authorized) begin
          if (write_q) reg_we = 1'b1;
          else         rsp_rdata_d = rd_val;
        end else begin
          excp = 1'b1;
          if (viol_cnt_q != '1) viol_cnt_d = viol_cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Request capture in IDLE; requests arriving in other states are not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      priv_q  <= '0;
    end else if (state_q == ST_IDLE && req_valid) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      priv_q  <= req_priv;
    end
  end

  // Register file, violation counter and held response fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register file is architecturally reset to zero, so it lives in flops with an explicit reset loop.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      viol_cnt_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_code_q  <= RSP_OK;
    end else begin
      if (reg_we) regs_q[idx] <= wr_val;
      viol_cnt_q  <= viol_cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_code_q  <= rsp_code_d;
    end
  end

  assign req_ready = rst_n && (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_code  = rsp_code_q;

endmodule

// File: tb/tb_csr_priv_responder.sv
// tb_csr_priv_responder: directed plus randomized checks of csr_priv_responder
// against a behavioural register-map model. Honors CSR_LOCK_EN like the design.
module tb_csr_priv_responder;

  localparam logic [11:0] BASE = 12'h060;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_priv;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  rsp_code;
  logic        excp;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the register map.
  logic [31:0] m_regs [8];
  int          m_viol;
  bit          m_lock;
  int          min_priv [8] = '{0, 1, 1, 1, 3, 3, 3, 3};

  always #5 clk = ~clk;

  csr_priv_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_priv  (req_priv),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_code  (rsp_code),
    .excp      (excp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_viol = 0;
    m_lock = 1'b0;
  endtask

  // One full transaction: predict from the model, drive, check every phase.
  task automatic txn(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                     input logic [1:0] pv, input int hold);
    int          off, idx, code, n;
    bit          in_rng;
    logic [31:0] rd;
    off    = int'(addr) - int'(BASE);
    in_rng = (off >= 0) && (off <= 7);
    idx    = in_rng ? off : 0;
    if (!in_rng)                                                   code = 2;
    else if (pv == 2'b10 || int'(pv) < min_priv[idx])              code = 1;
    else if (wr && (idx == 3 || (m_lock && idx >= 4 && idx <= 6))) code = 3;
    else                                                           code = 0;
    rd = (code == 0 && !wr) ? ((idx == 3) ? 32'(m_viol) : m_regs[idx]) : 32'h0;
    if (code != 0) begin
      if (m_viol < 255) m_viol++;
    end else if (wr) begin
      if (idx == 7) begin
`ifdef CSR_LOCK_EN
        m_lock    = m_lock | wd[0];
        m_regs[7] = {wd[31:1], m_lock};
`else
        m_regs[7] = wd;
`endif
      end else begin
        m_regs[idx] = wd;
      end
    end

    n = 0;
    while (!req_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_priv = pv;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("excp_in_check", 32'(excp), 32'(code != 0));
    check("rsp_valid_in_check", 32'(rsp_valid), 32'd0);
    check("ready_in_check", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("excp_after_check", 32'(excp), 32'd0);
    check("rsp_rdata", rsp_rdata, rd);
    check("rsp_err", 32'(rsp_err), 32'(code != 0));
    check("rsp_code", 32'(rsp_code), 32'(code));
    for (int h = 0; h < hold; h++) begin
      // A competing request while busy must be ignored.
      req_valid = 1'b1; req_write = 1'b1; req_addr = BASE; req_wdata = 32'hBADBAD00; req_priv = 2'b11;
      @(posedge clk); #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, rd);
      check("hold_code", 32'(rsp_code), 32'(code));
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("idle_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_priv = '0; rsp_ready = 1'b0;
    model_reset();
    #13;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_code", 32'(rsp_code), 32'd0);
    check("rst_excp", 32'(excp), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Directed plan.
    txn(1, BASE + 12'd0, 32'hDEADBEEF, 2'b11, 0);
    txn(0, BASE + 12'd0, 32'h0, 2'b00, 0);
    txn(1, 12'h064, 32'h1234, 2'b01, 0);
    txn(0, 12'h064, 32'h0, 2'b11, 0);
    txn(0, 12'h065, 32'h0, 2'b00, 0);
    txn(0, BASE + 12'd0, 32'h0, 2'b10, 0);
    txn(0, BASE + 12'd3, 32'h0, 2'b01, 0);
    txn(1, 12'h068, 32'h55, 2'b11, 0);
    txn(1, BASE + 12'd3, 32'hFF, 2'b01, 0);
    txn(0, BASE + 12'd3, 32'h0, 2'b01, 0);
    txn(0, 12'h05F, 32'h0, 2'b11, 0);
    txn(1, BASE + 12'd7, 32'hA5A5A5A4, 2'b11, 5);
    txn(0, BASE + 12'd0, 32'h0, 2'b11, 0);
    txn(0, BASE + 12'd7, 32'h0, 2'b11, 1);
    txn(0, BASE + 12'd7, 32'h0, 2'b01, 0);

    // Lock behaviour (plain scratch when the feature is not built).
    txn(1, BASE + 12'd7, 32'h1, 2'b11, 0);
    txn(1, 12'h065, 32'hCAFE0001, 2'b11, 0);
    txn(0, 12'h065, 32'h0, 2'b11, 0);
    txn(1, BASE + 12'd7, 32'h0, 2'b11, 0);
    txn(0, BASE + 12'd7, 32'h0, 2'b11, 0);
    txn(1, 12'h064, 32'h77, 2'b11, 0);
    txn(0, 12'h064, 32'h0, 2'b11, 0);

    // Reset asserted during CHECK of an M write to EPC.
    req_valid = 1'b1; req_write = 1'b1; req_addr = BASE + 12'd6; req_wdata = 32'h12345678; req_priv = 2'b11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_idle", 32'(req_ready), 32'd1);
    check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    txn(0, BASE + 12'd6, 32'h0, 2'b11, 0);
    txn(0, BASE + 12'd3, 32'h0, 2'b11, 0);

    // Randomized traffic around the mapped window.
    for (int i = 0; i < 120; i++) begin
      txn(1'($urandom_range(0, 1)), BASE - 12'd2 + 12'($urandom_range(0, 11)),
          $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 2));
    end

    // Violation counter saturation.
    for (int i = 0; i < 260; i++) txn(0, BASE + 12'd8, 32'h0, 2'b11, 0);
    txn(0, BASE + 12'd3, 32'h0, 2'b01, 0);
    txn(1, BASE + 12'd3, 32'h0, 2'b11, 0);
    txn(0, BASE + 12'd3, 32'h0, 2'b11, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
